// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM state and grant
// encodings plus the tie-break helper used when both requesters are active.
package rv32i_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INST = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_INST = 2'd1,
        GRANT_DATA = 2'd2
    } grant_e;

    localparam logic [3:0] INST_SEL = 4'hF;

    // Returns 1 when the data requester should win this IDLE sample.
    function automatic logic pick_data(input logic   stb_inst,
                                       input logic   stb_data,
                                       input grant_e last_grant,
                                       input logic   data_first);
        logic win;
        win = stb_data;
        if (stb_inst && stb_data) begin
            case (last_grant)
                GRANT_INST: win = 1'b1;
                GRANT_DATA: win = 1'b0;
                default:    win = data_first;
            endcase
        end
        return win;
    endfunction

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of the core-side stb/ack requesters and the single memory port.
// master = arbiter view, slave = the surrounding core/memory view.
interface rv32i_mem_arbiter_if;

    logic        i_stb_inst;
    logic [31:0] i_addr_inst;
    logic        o_ack_inst;
    logic [31:0] o_inst;

    logic        i_stb_data;
    logic        i_we_data;
    logic [31:0] i_addr_data;
    logic [31:0] i_wdata_data;
    logic [3:0]  i_sel_data;
    logic        o_ack_data;
    logic [31:0] o_rdata_data;
    logic        o_err;

    logic        o_mem_stb;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_sel;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    modport master (
        input  i_stb_inst, i_addr_inst,
        output o_ack_inst, o_inst,
        input  i_stb_data, i_we_data, i_addr_data, i_wdata_data, i_sel_data,
        output o_ack_data, o_rdata_data, o_err,
        output o_mem_stb, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_sel,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        output i_stb_inst, i_addr_inst,
        input  o_ack_inst, o_inst,
        output i_stb_data, i_we_data, i_addr_data, i_wdata_data, i_sel_data,
        input  o_ack_data, o_rdata_data, o_err,
        input  o_mem_stb, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_sel,
        output i_mem_ack, i_mem_rdata
    );

endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access with
// data priority, alternation under contention, withdrawal swallowing and a timeout.
module rv32i_mem_arbiter
    import rv32i_mem_arbiter_pkg::*;
#(
    parameter bit          DATA_FIRST     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    rv32i_mem_arbiter_if.master  bus,
    output arb_state_e           o_state
);

    // Handshake: a requester holds stb high (level) until it sees its one-cycle
    // ack pulse or withdraws; the memory sees stb held with stable address/data
    // until it returns a one-cycle i_mem_ack.

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : '0;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e       state_q, state_d;
    grant_e           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             orphan_q, orphan_d;
    logic             mem_stb_q, mem_stb_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_sel_q, mem_sel_d;

    logic             owner_stb;
    logic             live;
    logic             timeout;
    logic             ack_inst;
    logic             ack_data;
    logic             err;
    logic [31:0]      rdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        orphan_d     = orphan_q;
        mem_stb_d    = mem_stb_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_sel_d    = mem_sel_q;
        ack_inst     = 1'b0;
        ack_data     = 1'b0;
        err          = 1'b0;
        rdata        = bus.i_mem_rdata;

        owner_stb = (state_q == ARB_INST) ? bus.i_stb_inst : bus.i_stb_data;
        // Requester must still be asking in this very cycle and never have let go.
        live      = owner_stb && !orphan_q;
        timeout   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

        case (state_q)
            ARB_IDLE: begin
                cnt_d    = '0;
                orphan_d = 1'b0;
                if (bus.i_stb_inst || bus.i_stb_data) begin
                    mem_stb_d = 1'b1;
                    if (pick_data(bus.i_stb_inst, bus.i_stb_data, last_grant_q, DATA_FIRST)) begin
                        state_d     = ARB_DATA;
                        mem_we_d    = bus.i_we_data;
                        mem_addr_d  = bus.i_addr_data;
                        mem_wdata_d = bus.i_wdata_data;
                        mem_sel_d   = bus.i_sel_data;
                    end else begin
                        state_d     = ARB_INST;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.i_addr_inst;
                        mem_wdata_d = '0;
                        mem_sel_d   = INST_SEL;
                    end
                end
            end
            ARB_INST, ARB_DATA: begin
                if (!owner_stb) begin
                    orphan_d = 1'b1;
                end
                if (bus.i_mem_ack || timeout) begin
                    ack_inst     = live && (state_q == ARB_INST);
                    ack_data     = live && (state_q == ARB_DATA);
                    // A real ack in the timeout cycle wins; the access completed normally.
                    err          = live && !bus.i_mem_ack;
                    rdata        = bus.i_mem_ack ? bus.i_mem_rdata : 32'd0;
                    mem_stb_d    = 1'b0;
                    state_d      = ARB_IDLE;
                    last_grant_d = (state_q == ARB_INST) ? GRANT_INST : GRANT_DATA;
                    orphan_d     = 1'b0;
                    cnt_d        = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_stb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_NONE;
            cnt_q        <= '0;
            orphan_q     <= 1'b0;
            mem_stb_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            orphan_q     <= orphan_d;
            mem_stb_q    <= mem_stb_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_sel_q    <= mem_sel_d;
        end
    end

    assign bus.o_ack_inst   = ack_inst;
    assign bus.o_ack_data   = ack_data;
    assign bus.o_err        = err;
    assign bus.o_inst       = rdata;
    assign bus.o_rdata_data = rdata;
    assign bus.o_mem_stb    = mem_stb_q;
    assign bus.o_mem_we     = mem_we_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_wdata  = mem_wdata_q;
    assign bus.o_mem_sel    = mem_sel_q;
    assign o_state          = state_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: fetch-only stream, contention order,
// store, withdrawal, timeout, ack/timeout tie and reset mid-access.
module tb_rv32i_mem_arbiter;
    import rv32i_mem_arbiter_pkg::*;

    localparam logic [31:0] RD_KEY = 32'hC0DE_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    arb_state_e state;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: acks mem_lat cycles after stb rises (0 = same cycle).
    int   wait_cnt;
    int   mem_lat;
    logic mem_en;
    logic force_ack;

    always #5 clk = ~clk;

    rv32i_mem_arbiter_if bus ();

    rv32i_mem_arbiter #(
        .DATA_FIRST     (1'b1),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_state (state)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                wait_cnt <= 0;
        else if (bus.o_mem_stb && !bus.i_mem_ack)  wait_cnt <= wait_cnt + 1;
        else                                       wait_cnt <= 0;
    end

    assign bus.i_mem_ack   = force_ack | (mem_en & bus.o_mem_stb & (wait_cnt >= mem_lat));
    assign bus.i_mem_rdata = bus.o_mem_addr ^ RD_KEY;

    function automatic logic [31:0] exp_rd(input logic [31:0] addr);
        return addr ^ RD_KEY;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        bus.i_stb_inst   = 1'b0;
        bus.i_addr_inst  = '0;
        bus.i_stb_data   = 1'b0;
        bus.i_we_data    = 1'b0;
        bus.i_addr_data  = '0;
        bus.i_wdata_data = '0;
        bus.i_sel_data   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drop_all();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state",   32'(state), 32'(ARB_IDLE));
        check_eq("rst_mem_stb", 32'(bus.o_mem_stb), 32'd0);
        check_eq("rst_mem_addr", bus.o_mem_addr, 32'd0);
        check_eq("rst_mem_sel", 32'(bus.o_mem_sel), 32'd0);
        check_eq("rst_acks",    {29'd0, bus.o_ack_inst, bus.o_ack_data, bus.o_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mem_lat   = 0;
        mem_en    = 1'b1;
        force_ack = 1'b0;
        do_reset();

        // Fetch only, zero-latency memory: one ack every two cycles.
        bus.i_stb_inst  = 1'b1;
        bus.i_addr_inst = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t1_ack_inst", 32'(bus.o_ack_inst), 32'd1);
            check_eq("t1_ack_data", 32'(bus.o_ack_data), 32'd0);
            check_eq("t1_addr",     bus.o_mem_addr, 32'(k * 4));
            check_eq("t1_inst",     bus.o_inst, exp_rd(32'(k * 4)));
            check_eq("t1_sel",      32'(bus.o_mem_sel), 32'hF);
            if (k == 2) bus.i_stb_inst = 1'b0;
            else        bus.i_addr_inst = bus.i_addr_inst + 32'd4;
            tick();
            check_eq("t1_idle_ack", 32'(bus.o_ack_inst), 32'd0);
            check_eq("t1_idle_stb", 32'(bus.o_mem_stb), 32'd0);
        end

        // Contention from reset: D, I, D, I.
        do_reset();
        bus.i_stb_inst  = 1'b1;
        bus.i_addr_inst = 32'h1000;
        bus.i_stb_data  = 1'b1;
        bus.i_addr_data = 32'h2000;
        bus.i_sel_data  = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t2_addr",     bus.o_mem_addr, (k % 2 == 0) ? 32'h2000 : 32'h1000);
            check_eq("t2_ack_data", 32'(bus.o_ack_data), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("t2_ack_inst", 32'(bus.o_ack_inst), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k == 3) drop_all();
            tick();
            check_eq("t2_idle_stb", 32'(bus.o_mem_stb), 32'd0);
        end

        // Store with partial byte enables, one-cycle memory latency.
        mem_lat          = 1;
        bus.i_stb_data   = 1'b1;
        bus.i_we_data    = 1'b1;
        bus.i_addr_data  = 32'h100;
        bus.i_wdata_data = 32'hDEADBEEF;
        bus.i_sel_data   = 4'b0011;
        tick();
        check_eq("t3_stb",      32'(bus.o_mem_stb), 32'd1);
        check_eq("t3_we",       32'(bus.o_mem_we), 32'd1);
        check_eq("t3_sel",      32'(bus.o_mem_sel), 32'h3);
        check_eq("t3_addr",     bus.o_mem_addr, 32'h100);
        check_eq("t3_wdata",    bus.o_mem_wdata, 32'hDEADBEEF);
        check_eq("t3_early",    32'(bus.o_ack_data), 32'd0);
        tick();
        check_eq("t3_ack_data", 32'(bus.o_ack_data), 32'd1);
        check_eq("t3_ack_inst", 32'(bus.o_ack_inst), 32'd0);
        check_eq("t3_err",      32'(bus.o_err), 32'd0);
        drop_all();
        tick();
        check_eq("t3_idle_stb", 32'(bus.o_mem_stb), 32'd0);

        // Fetch withdrawn after grant; its ack is swallowed, re-request regranted.
        mem_lat         = 2;
        bus.i_stb_inst  = 1'b1;
        bus.i_addr_inst = 32'h40;
        tick();
        check_eq("t4_addr0", bus.o_mem_addr, 32'h40);
        bus.i_stb_inst = 1'b0;
        tick();
        check_eq("t4_noack1", 32'(bus.o_ack_inst), 32'd0);
        tick();
        check_eq("t4_swallow", 32'(bus.o_ack_inst), 32'd0);
        check_eq("t4_noerr",   32'(bus.o_err), 32'd0);
        bus.i_stb_inst  = 1'b1;
        bus.i_addr_inst = 32'h80;
        #1;
        check_eq("t4_reassert_ack", 32'(bus.o_ack_inst), 32'd0);
        tick();
        check_eq("t4_idle", 32'(state), 32'(ARB_IDLE));
        tick();
        check_eq("t4_new_addr", bus.o_mem_addr, 32'h80);
        tick();
        tick();
        check_eq("t4_ack_new", 32'(bus.o_ack_inst), 32'd1);
        check_eq("t4_inst",    bus.o_inst, exp_rd(32'h80));
        drop_all();
        tick();

        // Timeout with no memory response, then a stray late ack.
        mem_en          = 1'b0;
        bus.i_stb_data  = 1'b1;
        bus.i_addr_data = 32'h200;
        bus.i_sel_data  = 4'hF;
        tick();
        check_eq("t5_wait1_ack", 32'(bus.o_ack_data), 32'd0);
        tick();
        tick();
        check_eq("t5_wait3_err", 32'(bus.o_err), 32'd0);
        tick();
        check_eq("t5_to_ack",   32'(bus.o_ack_data), 32'd1);
        check_eq("t5_to_err",   32'(bus.o_err), 32'd1);
        check_eq("t5_to_rdata", bus.o_rdata_data, 32'd0);
        drop_all();
        tick();
        force_ack = 1'b1;
        #1;
        check_eq("t5_late_ack",  32'(bus.o_ack_data), 32'd0);
        check_eq("t5_late_err",  32'(bus.o_err), 32'd0);
        check_eq("t5_late_stb",  32'(bus.o_mem_stb), 32'd0);
        tick();
        force_ack = 1'b0;
        check_eq("t5_still_idle", 32'(state), 32'(ARB_IDLE));
        mem_en = 1'b1;

        // Ack lands in the timeout cycle: ack wins, no error.
        mem_lat         = 3;
        bus.i_stb_data  = 1'b1;
        bus.i_addr_data = 32'h300;
        bus.i_sel_data  = 4'hF;
        tick();
        tick();
        tick();
        check_eq("t6_wait_ack", 32'(bus.o_ack_data), 32'd0);
        tick();
        check_eq("t6_ack",   32'(bus.o_ack_data), 32'd1);
        check_eq("t6_err",   32'(bus.o_err), 32'd0);
        check_eq("t6_rdata", bus.o_rdata_data, exp_rd(32'h300));
        drop_all();
        tick();

        // Reset in the middle of a data access.
        bus.i_stb_data  = 1'b1;
        bus.i_addr_data = 32'h400;
        bus.i_sel_data  = 4'hF;
        tick();
        check_eq("t7_stb_before", 32'(bus.o_mem_stb), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t7_stb_rst",   32'(bus.o_mem_stb), 32'd0);
        check_eq("t7_addr_rst",  bus.o_mem_addr, 32'd0);
        check_eq("t7_state_rst", 32'(state), 32'(ARB_IDLE));
        drop_all();
        @(negedge clk);
        rst_n     = 1'b1;
        force_ack = 1'b1;
        #1;
        check_eq("t7_post_ack_data", 32'(bus.o_ack_data), 32'd0);
        check_eq("t7_post_ack_inst", 32'(bus.o_ack_inst), 32'd0);
        check_eq("t7_post_err",      32'(bus.o_err), 32'd0);
        tick();
        force_ack = 1'b0;
        check_eq("t7_post_idle", 32'(state), 32'(ARB_IDLE));
        check_eq("t7_post_stb",  32'(bus.o_mem_stb), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
